// File: rtl/sc_io_pkg.sv
// Shared constants for the sc_computer board I/O block: segment codes,
// display limit and display FSM state encoding.
package sc_io_pkg;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam int unsigned MAX_DISPLAY = 999999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Non-decimal nibbles map to blank instead of indexing past the table.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] seg;
    seg = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (d == i[3:0]) seg = SEG_DIGIT[i];
    end
    return seg;
  endfunction

endpackage

// File: rtl/sc_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per cycle.
// start loads bin; done is high in the cycle that applies the final step.
module sc_bin2bcd #(
  parameter int BIN_BITS = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [BIN_BITS-1:0] bin,
  output logic                done,
  output logic [23:0]         bcd
);
  import sc_io_pkg::*;

  localparam int CW = $clog2(BIN_BITS + 1);

  logic [BIN_BITS-1:0] shift;
  logic [CW-1:0]       count;
  logic                active;
  logic [23:0]         adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // The result in bcd is complete from the cycle after done.
  assign done = active && (count == CW'(BIN_BITS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      shift  <= '0;
      count  <= '0;
      active <= 1'b0;
      bcd    <= '0;
    end else if (start) begin
      shift  <= bin;
      count  <= '0;
      active <= 1'b1;
      bcd    <= '0;
    end else if (active) begin
      bcd   <= {adj[22:0], shift[BIN_BITS-1]};
      shift <= shift << 1;
      count <= count + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/sc_io_peripheral.sv
// Board side of the sc_computer I/O ports: debounced switches feed the CPU
// input ports, and the CPU output port is shown in decimal on HEX5..HEX0.
module sc_io_peripheral #(
  parameter int SW_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BIN_BITS        = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic [31:0]         out_port,
  output logic [31:0]         in_port0,
  output logic [31:0]         in_port1,
  output logic [6:0]          hex0,
  output logic [6:0]          hex1,
  output logic [6:0]          hex2,
  output logic [6:0]          hex3,
  output logic [6:0]          hex4,
  output logic [6:0]          hex5,
  output logic                busy
);
  import sc_io_pkg::*;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [SW_WIDTH-1:0] sw_meta, sw_s, candidate, stable;
  logic [CNT_W-1:0]    cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta   <= '0;
      sw_s      <= '0;
      candidate <= '0;
      stable    <= '0;
      cnt       <= '0;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
      // Any change restarts the count; the counter parks once accepted.
      if (sw_s != candidate) begin
        candidate <= sw_s;
        cnt       <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= candidate;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign in_port0 = {27'b0, stable[4:0]};
  assign in_port1 = {27'b0, stable[9:5]};

  state_t      state;
  logic [31:0] shown_val;
  logic        out_of_range;
  logic        start;
  logic        conv_done;
  logic [23:0] bcd;
  logic [41:0] seg_next;
  logic        lead;

  assign out_of_range = (out_port > 32'(MAX_DISPLAY));
  assign start        = (state == IDLE) && (out_port != shown_val) && !out_of_range;

  sc_bin2bcd #(.BIN_BITS(BIN_BITS)) u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bin   (out_port[BIN_BITS-1:0]),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    seg_next = '0;
    lead     = 1'b1;
    if (shown_val > 32'(MAX_DISPLAY)) begin
      seg_next = {6{SEG_DASH}};
    end else begin
      for (int i = 5; i >= 1; i--) begin
        if (bcd[4*i +: 4] != 4'd0) lead = 1'b0;
        seg_next[7*i +: 7] = lead ? SEG_BLANK : digit_seg(bcd[4*i +: 4]);
      end
      seg_next[6:0] = digit_seg(bcd[3:0]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shown_val <= '0;
      hex0      <= SEG_DIGIT[0];
      hex1      <= SEG_BLANK;
      hex2      <= SEG_BLANK;
      hex3      <= SEG_BLANK;
      hex4      <= SEG_BLANK;
      hex5      <= SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          // Out-of-range values need no digits, so they skip straight to LOAD.
          if (out_port != shown_val) begin
            shown_val <= out_port;
            state     <= out_of_range ? LOAD : CONV;
          end
        end
        CONV: if (conv_done) state <= LOAD;
        LOAD: begin
          {hex5, hex4, hex3, hex2, hex1, hex0} <= seg_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sc_io_peripheral.sv
// Bench for sc_io_peripheral: directed scenarios plus random traffic, checked
// every cycle against a decimal-arithmetic model of the display and debouncer.
module tb_sc_io_peripheral;

  localparam int DC = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  sw = '0;
  logic [31:0] out_port = '0;
  logic [31:0] in_port0, in_port1;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  sc_io_peripheral #(
    .SW_WIDTH(10), .DEBOUNCE_CYCLES(DC), .BIN_BITS(20)
  ) dut (
    .clock(clock), .reset(reset), .sw(sw), .out_port(out_port),
    .in_port0(in_port0), .in_port1(in_port1),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [41:0] render(input logic [31:0] v);
    logic [41:0] r;
    longint unsigned p;
    r = '0;
    if (v > 32'd999999) return {6{7'b0111111}};
    p = 1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0 && v < p) r[7*i +: 7] = 7'h7F;
      else r[7*i +: 7] = seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  bit          m_valid = 1'b0;
  logic [9:0]  m_s1, m_s2, m_prev, m_stable;
  int          m_run;
  logic [31:0] m_shown;
  int          m_timer;
  logic [41:0] m_disp;

  always @(posedge clock) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_run = 1; m_stable = '0;
      m_shown = '0; m_timer = 0; m_disp = render(32'd0); m_valid = 1'b1;
    end else begin
      // A switch value is accepted once DC+1 consecutive synced samples agree.
      if (m_s2 == m_prev) begin
        if (m_run < DC + 1) m_run++;
      end else begin
        m_prev = m_s2;
        m_run  = 1;
      end
      if (m_run >= DC + 1) m_stable = m_prev;
      m_s2 = m_s1;
      m_s1 = sw;
      // Display: 21 busy edges for a conversion, 1 for the dash path.
      if (m_timer == 0) begin
        if (out_port != m_shown) begin
          m_shown = out_port;
          m_timer = (out_port > 32'd999999) ? 1 : 21;
        end
      end else begin
        m_timer--;
        if (m_timer == 0) m_disp = render(m_shown);
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("in_port0", in_port0, {27'b0, m_stable[4:0]});
      check("in_port1", in_port1, {27'b0, m_stable[9:5]});
      check("hex", {hex5, hex4, hex3, hex2, hex1, hex0}, m_disp);
      check("busy", busy, m_timer != 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int n;
    logic [9:0]  target;
    logic [31:0] v;

    // 1. reset display
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(5);
    check("rst_in0", in_port0, 32'd0);
    check("rst_in1", in_port1, 32'd0);
    check("rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {{5{7'h7F}}, 7'b1000000});
    check("rst_busy", busy, 1'b0);

    // 2. bounced switch change
    target = 10'b1010000111;
    sw = target;          cycles(1);
    sw = target ^ 10'd1;  cycles(1);
    sw = target;          cycles(1);
    sw = target ^ 10'd1;  cycles(1);
    sw = target;
    cycles(6);
    check("deb_early", in_port0, 32'd0);
    cycles(1);
    check("deb_in0", in_port0, 32'd7);
    check("deb_in1", in_port1, 32'd20);

    // 3. 123: busy for 21 cycles
    out_port = 32'd123;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy) n++;
    end
    check("busy_len", n, 21);
    check("hex_123", {hex5, hex4, hex3, hex2, hex1, hex0},
          {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30});

    // 4. largest value, then first out-of-range value
    out_port = 32'd999999;
    cycles(30);
    check("hex_999999", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h10}});
    out_port = 32'd1000000;
    cycles(1);
    check("dash_busy", busy, 1'b1);
    cycles(1);
    check("dash_busy_end", busy, 1'b0);
    check("hex_dash", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'b0111111}});

    // 5. value changed mid-conversion
    out_port = 32'd42;
    cycles(5);
    out_port = 32'd7;
    cycles(17);
    check("hex_42", {hex1, hex0}, {7'h19, 7'h24});
    cycles(21);
    check("hex_42_hold", hex0, 7'h24);
    cycles(1);
    check("hex_7", {hex5, hex4, hex3, hex2, hex1, hex0}, {{5{7'h7F}}, 7'h78});

    // 6. reset during a conversion
    out_port = 32'd555;
    cycles(10);
    reset = 1'b1;
    out_port = 32'd0;
    cycles(1);
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {{5{7'h7F}}, 7'b1000000});
    cycles(30);
    check("midrst_after", {hex2, hex1, hex0}, {7'h7F, 7'h7F, 7'b1000000});

    // random traffic
    for (int it = 0; it < 80; it++) begin
      target = 10'($urandom_range(0, 1023));
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        sw = target ^ (10'd1 << $urandom_range(0, 9));
        cycles(1);
        sw = target;
        cycles(int'($urandom_range(1, 2)));
      end
      sw = target;
      case ($urandom_range(0, 4))
        0: v = $urandom_range(0, 999);
        1: v = $urandom_range(0, 999999);
        2: v = 32'd1000000 + $urandom_range(0, 50000000);
        3: v = out_port;
        default: v = $urandom;
      endcase
      out_port = v;
      if ($urandom_range(0, 9) == 0) begin
        cycles(int'($urandom_range(1, 15)));
        out_port = $urandom_range(0, 999999);
      end
      if ($urandom_range(0, 19) == 0) begin
        cycles(int'($urandom_range(1, 20)));
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
      end
      cycles(int'($urandom_range(1, 45)));
    end
    cycles(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
